platform_rom_streamer: RTL and testbench
========================================

# platform_rom_streamer

Avalon-MM read master that fetches a contiguous range of 32-bit words from the platform on-chip ROM's slave port and delivers them as a valid/ready word stream. The master interface drives address, chipselect and clken with a fixed read latency and no waitrequest. A small credit-managed FIFO absorbs in-flight reads so the consumer can apply backpressure. It sits between the ROM and boot/loader logic that needs sequential ROM contents.

## Interface
- ADDR_W, 12, word address width of ROM slave (4096 words)
- DATA_W, 32, word width
- READ_LATENCY, 1, cycles from address/chipselect sample to valid readdata (≥1)
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥ READ_LATENCY+1
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  words to read, 0..2^ADDR_W
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when last word accepted by consumer
- avm_address  out  ADDR_W  word address to ROM
- avm_chipselect  out  1  read strobe, one word per cycle asserted
- avm_byteenable  out  DATA_W/8  constant all-ones
- avm_write  out  1  constant 0
- avm_clken  out  1  constant 1
- avm_readdata  in  DATA_W  ROM read data
- out_data  out  DATA_W  stream word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when valid&ready
- out_last  out  1  marks final word of range

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches base_addr into addr counter and word_count into remaining counters. Goes to ISSUE if count>0, else DONE.
- ISSUE: assert avm_chipselect with avm_address=addr when credits allow (fifo_count + inflight < FIFO_DEPTH). Each issue increments addr mod 2^ADDR_W (wrap 0xFFF→0x000) and decrements issue_remaining. After the final issue, go to DRAIN.
- Return path: shift register of depth READ_LATENCY tracks chipselect. At its output, avm_readdata is pushed into the FIFO. The FIFO never overflows by construction.
- DRAIN: wait until deliver_remaining==0, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- out_last=1 with out_valid when deliver_remaining==1.
- start outside IDLE is ignored.
- avm_chipselect deasserts whenever credits are exhausted; there are no bubbles otherwise.
- busy=1 in ISSUE, DRAIN, DONE.

## Timing
- Reset values: busy=0, done=0, avm_chipselect=0, avm_address=0, out_valid=0, out_last=0, out_data=0, FIFO empty, inflight=0, FSM=IDLE.
- start in cycle T: first chipselect in T+1. First out_valid in T+1+READ_LATENCY+1, because the FIFO is registered.
- With out_ready held high, throughput is 1 word/cycle. done asserts the cycle after the last handshake.
- Simultaneous FIFO push and pop in the same cycle: count is unchanged and both occur.
- Reset asserted mid-transfer: all state clears immediately. In-flight ROM data is discarded and no done is generated.
- word_count=2^ADDR_W reads every word once, ending at base_addr-1 after wrap.

## Configuration
- PLATFORM_ROM_STREAMER_CSUM_EN defined:
  - Adds output port checksum [DATA_W-1:0], a sum mod 2^DATA_W of all delivered words.
  - Cleared on accepted start; valid and stable from the done pulse until the next start.
  - Reset value is 0.
- PLATFORM_ROM_STREAMER_CSUM_EN undefined: no checksum port and no adder logic.

## Structure
- Package platform_rom_streamer_pkg contains:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE)
  - default ADDR_W/DATA_W constants
  - credit-width helper function
- Sub-module platform_rom_streamer_fifo: synchronous FIFO, FIFO_DEPTH×DATA_W, with count output. Used for the return path only.

## Test plan
- base_addr=0x010, word_count=4, out_ready=1, ROM[i]=i: stream 0x10..0x13, out_last on 0x13, done one cycle after, 4 chipselects.
- word_count=0: done pulses at T+1, with no chipselect and no out_valid.
- base_addr=0xFFE, word_count=4: addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- word_count=16, out_ready toggled 1-of-4 cycles: inflight+fifo_count ≤ FIFO_DEPTH always, with no lost or duplicated words.
- reset_n low for 1 cycle during ISSUE of an 8-word read: all outputs return to reset values, and a subsequent start runs a clean transfer.
- CSUM_EN, ROM words 1,2,3,0xFFFFFFFF: checksum=0x00000005 at done.

Source files
------------

// File: rtl/platform_rom_streamer_pkg.sv
// platform_rom_streamer_pkg: shared FSM states, default widths and credit sizing helper
package platform_rom_streamer_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/platform_rom_streamer_if.sv
// platform_rom_streamer_if: Avalon-MM read bus between the streamer and the ROM slave port
interface platform_rom_streamer_if
  import platform_rom_streamer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic [DATA_W/8-1:0] byteenable;
  logic                write;
  logic                clken;
  logic [DATA_W-1:0]   readdata;
  modport master (output address, chipselect, byteenable, write, clken, input readdata);
  modport slave (input address, chipselect, byteenable, write, clken, output readdata);
endinterface

// File: rtl/platform_rom_streamer_fifo.sv
// platform_rom_streamer_fifo: registered return-path FIFO; caller guarantees no push when full, no pop when empty
module platform_rom_streamer_fifo
  import platform_rom_streamer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic [credit_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = credit_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // pointer and occupancy update; push and pop in one cycle leave the count unchanged
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // storage array carries no reset; empty entries are masked at the output
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= din;
  // pointer and count state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout  = (cnt_q != '0) ? mem[rd_q] : '0;
  assign count = cnt_q;
endmodule

// File: rtl/platform_rom_streamer.sv
// platform_rom_streamer: credit-limited Avalon-MM ROM reader feeding a valid/ready stream (PLATFORM_ROM_STREAMER_CSUM_EN adds checksum)
module platform_rom_streamer
  import platform_rom_streamer_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  platform_rom_streamer_if.master avm,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);
  localparam int CW = credit_w(FIFO_DEPTH);
  localparam int OW = CW + 1;
  localparam int NW = ADDR_W + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NW-1:0] iss_q, iss_d, dlv_q, dlv_d, iss_next;
  logic cs_q, cs_d, busy_q, busy_d, done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] committed;
  logic push, pop, credit;
  assign avm.address    = addr_q;
  assign avm.chipselect = cs_q;
  assign avm.byteenable = '1;
  assign avm.write      = 1'b0;
  assign avm.clken      = 1'b1;
  assign push      = pipe_q[READ_LATENCY-1];
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid && dlv_q == NW'(1);
  assign busy      = busy_q;
  assign done      = done_q;
  // words already claimed on FIFO space: buffered, in the ROM pipe, or issued this cycle
  assign committed = OW'(fifo_count) + OW'($countones(pipe_q)) + OW'(cs_q) - OW'(pop);
  assign credit    = committed < OW'(FIFO_DEPTH);
  platform_rom_streamer_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (avm.readdata),
    .pop     (pop),
    .dout    (out_data),
    .count   (fifo_count)
  );
  // next-state: counters advance on each issue/delivery, chipselect is decided a cycle ahead
  always_comb begin
    state_d  = state_q;
    pipe_d   = READ_LATENCY'({pipe_q, cs_q});
    addr_d   = addr_q + ADDR_W'(cs_q);
    iss_next = iss_q - NW'(cs_q);
    iss_d    = iss_next;
    dlv_d    = dlv_q - NW'(pop);
    cs_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = base_addr;
        iss_d   = word_count;
        dlv_d   = word_count;
        busy_d  = 1'b1;
        cs_d    = word_count != '0;
        done_d  = word_count == '0;
        state_d = (word_count != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        cs_d    = iss_next != '0 && credit;
        state_d = (iss_next == '0) ? DRAIN : ISSUE;
      end
      DRAIN: if (dlv_d == '0) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // FSM and registered bus/status outputs; reset abandons any transfer without a done
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      iss_q   <= '0;
      dlv_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      dlv_q   <= dlv_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pipe_q  <= pipe_d;
    end
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  // cleared on accepted start, accumulates every delivered word
  always_comb csum_d = (state_q == IDLE && start) ? '0 : pop ? csum_q + out_data : csum_q;
  // checksum register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) csum_q <= '0;
    else csum_q <= csum_d;
  assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_platform_rom_streamer.sv
// tb_platform_rom_streamer: randomized self-checking bench against a word-sequence reference model
module tb_platform_rom_streamer;
  import platform_rom_streamer_pkg::*;
  localparam int AW = 12, DW = 32, DEPTH = 4, NW = 1 << AW;
  logic clk = 0, reset_n = 0, start = 0, out_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] word_count = '0;
  logic busy, done, out_valid, out_last;
  logic [DW-1:0] out_data;
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
  logic [DW-1:0] checksum;
`endif
  platform_rom_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();
  platform_rom_streamer #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .avm        (avm.master),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
    ,
    .checksum   (checksum)
`endif
  );
  always #5 clk = ~clk;
  logic [DW-1:0] rom [NW];
  always @(posedge clk) if (avm.chipselect) avm.readdata <= rom[avm.address];
  int cyc = 0, n_cmp = 0, n_err = 0, ready_mode = 0;
  int cs_n, dlv_n, done_n, ovf, first_cs, first_val, last_hs, done_cyc;
  bit busy_at_done;
  logic [AW-1:0] cs_addrs[$];
  logic [DW-1:0] got[$];
  bit lasts[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic clear_mon();
    cs_n = 0; dlv_n = 0; done_n = 0; ovf = 0; first_cs = -1; first_val = -1; last_hs = -1; done_cyc = -1;
    busy_at_done = 0; cs_addrs.delete(); got.delete(); lasts.delete();
  endtask
  always @(negedge clk) begin
    if (avm.chipselect) begin
      cs_addrs.push_back(avm.address);
      cs_n++;
      if (first_cs < 0) first_cs = cyc;
    end
    if (cs_n - dlv_n > DEPTH) ovf++;
    if (out_valid && first_val < 0) first_val = cyc;
    if (out_valid && out_ready) begin
      got.push_back(out_data); lasts.push_back(out_last); dlv_n++; last_hs = cyc;
    end
    if (done) begin done_n++; done_cyc = cyc; busy_at_done = busy; end
  end
  initial forever begin
    @(posedge clk); #1;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
  end
  task automatic test_stream(input string name, input int base, input int wc, input int mode);
    int t, ia, id, il, exp_done;
    ready_mode = mode;
    clear_mon();
    @(posedge clk); #1;
    start = 1; base_addr = AW'(base); word_count = (AW+1)'(wc); t = cyc;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 20000 && done_n == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ia = -1; id = -1; il = -1;
    for (int i = 0; i < cs_addrs.size() && i < wc; i++) if (ia < 0 && cs_addrs[i] !== AW'(base + i)) ia = i;
    for (int i = 0; i < got.size() && i < wc; i++) begin
      if (id < 0 && got[i] !== rom[(base + i) % NW]) id = i;
      if (il < 0 && lasts[i] !== (i == wc - 1)) il = i;
    end
    n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL %s done_pulses got %0d want 1", name, done_n); end
    n_cmp++; if (cs_n != wc) begin n_err++; $display("FAIL %s chipselects got %0d want %0d", name, cs_n, wc); end
    n_cmp++; if (got.size() != wc) begin n_err++; $display("FAIL %s words got %0d want %0d", name, got.size(), wc); end
    n_cmp++; if (ia >= 0) begin n_err++; $display("FAIL %s addr[%0d] got %h want %h", name, ia, cs_addrs[ia], AW'(base + ia)); end
    n_cmp++; if (id >= 0) begin n_err++; $display("FAIL %s data[%0d] got %h want %h", name, id, got[id], rom[(base + id) % NW]); end
    n_cmp++; if (il >= 0) begin n_err++; $display("FAIL %s last[%0d] got %0d want %0d", name, il, lasts[il], il == wc - 1); end
    n_cmp++; if (first_cs != (wc > 0 ? t + 1 : -1)) begin n_err++; $display("FAIL %s first_cs got %0d want %0d", name, first_cs, wc > 0 ? t + 1 : -1); end
    n_cmp++; if (first_val != (wc > 0 ? t + 3 : -1)) begin n_err++; $display("FAIL %s first_valid got %0d want %0d", name, first_val, wc > 0 ? t + 3 : -1); end
    exp_done = wc > 0 ? last_hs + 1 : t + 1;
    n_cmp++; if (done_cyc != exp_done) begin n_err++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done); end
    n_cmp++; if (busy_at_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL %s busy done/after got %0d/%0d want 1/0", name, busy_at_done, busy); end
    n_cmp++; if (ovf != 0) begin n_err++; $display("FAIL %s outstanding_over_depth got %0d want 0", name, ovf); end
    if (mode == 0 && wc > 0) begin
      n_cmp++; if (last_hs != t + 2 + wc) begin n_err++; $display("FAIL %s last_handshake got %0d want %0d", name, last_hs, t + 2 + wc); end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, avm.chipselect, out_valid, out_last} !== 5'b0) begin n_err++; $display("FAIL reset flags got %b want 00000", {busy, done, avm.chipselect, out_valid, out_last}); end
    n_cmp++; if (avm.address !== '0 || out_data !== '0) begin n_err++; $display("FAIL reset addr/data got %h/%h want 0/0", avm.address, out_data); end
    n_cmp++; if (avm.byteenable !== 4'hF || avm.write !== 1'b0 || avm.clken !== 1'b1) begin n_err++; $display("FAIL reset constants got be=%h wr=%b ck=%b want F/0/1", avm.byteenable, avm.write, avm.clken); end
    @(posedge clk); #1;
    reset_n = 1;
  endtask
  task automatic test_basic();
    test_stream("basic", 'h010, 4, 0);
  endtask
  task automatic test_zero();
    test_stream("zero", 'h123, 0, 0);
  endtask
  task automatic test_wrap();
    test_stream("wrap", 'hFFE, 4, 0);
  endtask
  task automatic test_backpressure();
    test_stream("backpressure", int'($urandom_range(0, NW - 1)), 16, 1);
  endtask
  task automatic test_reset_mid();
    ready_mode = 0;
    clear_mon();
    @(posedge clk); #1;
    start = 1; base_addr = AW'($urandom_range(0, NW - 1)); word_count = 13'd8;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    n_cmp++; if ({busy, done, avm.chipselect, out_valid, out_last} !== 5'b0 || avm.address !== '0 || out_data !== '0) begin
      n_err++; $display("FAIL mid_reset outputs got %b addr %h data %h want all zero", {busy, done, avm.chipselect, out_valid, out_last}, avm.address, out_data);
    end
    @(posedge clk); #1;
    reset_n = 1;
    repeat (10) @(negedge clk);
    n_cmp++; if (done_n != 0 || got.size() != 0 || cs_n != 1) begin
      n_err++; $display("FAIL mid_reset residue got done=%0d words=%0d cs=%0d want 0/0/1", done_n, got.size(), cs_n);
    end
    test_stream("after_reset", 'h100, 8, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < NW; i++) rom[i] = $urandom;
    for (int k = 0; k < 6; k++)
      test_stream("random", int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 40)), int'($urandom_range(0, 2)));
  endtask
  task automatic test_full();
    test_stream("full_range", int'($urandom_range(0, NW - 1)), NW, 0);
  endtask
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
  task automatic test_csum();
    rom[12'h200] = 32'd1; rom[12'h201] = 32'd2; rom[12'h202] = 32'd3; rom[12'h203] = 32'hFFFF_FFFF;
    test_stream("csum", 'h200, 4, 2);
    n_cmp++; if (checksum !== 32'd5) begin n_err++; $display("FAIL csum got %h want 00000005", checksum); end
  endtask
`endif
  initial begin
    for (int i = 0; i < NW; i++) rom[i] = DW'(i);
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_full();
`ifdef PLATFORM_ROM_STREAMER_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
